// File: rtl/pin_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pin_timer_pkg
//  Description : Shared encodings for the pin timer bank: channel modes,
//                per-channel register offsets, CTRL/STATUS bit positions and
//                the one-shot state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pin_timer_pkg;

    // Channel output modes (CTRL[1:0]); the reserved code behaves as STATIC
    localparam logic [1:0] MODE_STATIC   = 2'd0;
    localparam logic [1:0] MODE_SQUARE   = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // Register offsets inside a channel's four-word block
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_PULSE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_MODE_LSB  = 0;
    localparam int CTRL_LEVEL_BIT = 2;
    localparam int CTRL_START_BIT = 3;

    // One-shot sequencer states
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Mode the hardware actually runs: the reserved code falls back to STATIC
    function automatic logic [1:0] eff_mode(input logic [1:0] mode);
        return (mode == MODE_RESERVED) ? MODE_STATIC : mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pin_timer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pin_timer_channel
//  Description : One pin-waveform generator: CTRL/PERIOD/PULSE registers, a
//                tick counter, the one-shot IDLE/RUN sequencer and the
//                registered pin. A register write in a tick cycle takes
//                priority and that tick is dropped for this channel.
//  Revision    : 1.0  initial release
// ============================================================================
module pin_timer_channel
    import pin_timer_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_wr_ctrl,
    input  logic             i_wr_period,
    input  logic             i_wr_pulse,
    input  logic [3:0]       i_ctrl_wdata,
    input  logic [DIV_W-1:0] i_val_wdata,
    output logic [1:0]       o_mode,
    output logic             o_level,
    output logic [DIV_W-1:0] o_period,
    output logic [DIV_W-1:0] o_pulse,
    output logic [DIV_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_pin
);

    localparam logic [DIV_W-1:0] c_ONE = 1;

    logic [1:0]       r_mode;
    logic             r_level;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_pulse;
    logic [DIV_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic             r_pin;

    logic [1:0] w_new_mode;
    logic [1:0] w_new_eff;
    logic [1:0] w_cur_eff;
    logic       w_mode_chg;
    logic       w_start;
    logic       w_period_end;
    logic       w_pulse_end;

    assign w_new_mode   = i_ctrl_wdata[CTRL_MODE_LSB +: 2];
    assign w_new_eff    = eff_mode(w_new_mode);
    assign w_cur_eff    = eff_mode(r_mode);
    assign w_mode_chg   = (w_new_mode != r_mode);
    assign w_start      = i_ctrl_wdata[CTRL_START_BIT];
    // Compares are done at DIV_W width so the counter wraps, never overflows
    assign w_period_end = (r_cnt == (r_period - c_ONE));
    assign w_pulse_end  = (r_cnt == (r_pulse - c_ONE));

    // Register file, counter, one-shot sequencer and pin; writes beat ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= MODE_STATIC;
            r_level  <= 1'b0;
            r_period <= '0;
            r_pulse  <= '0;
            r_cnt    <= '0;
            r_state  <= c_ST_IDLE;
            r_pin    <= 1'b0;
        end else if (i_wr_ctrl) begin
            r_mode  <= w_new_mode;
            r_level <= i_ctrl_wdata[CTRL_LEVEL_BIT];
            case (w_new_eff)
                MODE_SQUARE: begin
                    // Rewriting the same mode leaves the wave running
                    if (w_mode_chg) begin
                        r_cnt   <= '0;
                        r_pin   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                MODE_ONESHOT: begin
                    // Busy is only ever set in ONESHOT, so a mode change
                    // always arrives here idle
                    if (w_start && (r_state == c_ST_IDLE) && (r_pulse != '0)) begin
                        r_cnt   <= '0;
                        r_pin   <= 1'b1;
                        r_state <= c_ST_RUN;
                    end else if (w_mode_chg) begin
                        r_cnt   <= '0;
                        r_pin   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_pin   <= i_ctrl_wdata[CTRL_LEVEL_BIT];
                    r_state <= c_ST_IDLE;
                end
            endcase
        end else if (i_wr_period) begin
            r_period <= i_val_wdata;
            // A new half-period restarts the count; the pin level is kept
            if (w_cur_eff == MODE_SQUARE) begin
                r_cnt <= '0;
            end
        end else if (i_wr_pulse) begin
            r_pulse <= i_val_wdata;
        end else begin
            case (w_cur_eff)
                MODE_SQUARE: begin
                    if (r_period == '0) begin
                        r_cnt <= '0;
                        r_pin <= 1'b0;
                    end else if (i_tick) begin
                        if (w_period_end) begin
                            r_cnt <= '0;
                            r_pin <= ~r_pin;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if ((r_state == c_ST_RUN) && i_tick) begin
                        if (w_pulse_end) begin
                            r_cnt   <= '0;
                            r_pin   <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_mode   = r_mode;
    assign o_level  = r_level;
    assign o_period = r_period;
    assign o_pulse  = r_pulse;
    assign o_cnt    = r_cnt;
    assign o_busy   = (r_state == c_ST_RUN);
    assign o_pin    = r_pin;

endmodule
`default_nettype wire

// File: rtl/pin_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pin_timer_bank
//  Description : Memory-mapped bank of NUM_CH pin-waveform generators
//                (static level, square wave, one-shot pulse) sharing a
//                PRESCALE-cycle tick. Holds the prescaler, the address
//                decode and the registered read mux.
//  Revision    : 1.0  initial release
// ============================================================================
module pin_timer_bank
    import pin_timer_pkg::*;
#(
    parameter int          NUM_CH    = 8,
    parameter int          DIV_W     = 16,
    parameter int          PRESCALE  = 50,
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic [11:0]       address,
    input  logic [31:0]       data,
    output logic [31:0]       q,
    output logic [NUM_CH-1:0] pins,
    output logic              tick
);

    localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          PS_W     = $clog2(PRESCALE);
    localparam logic [12:0] c_WIN_LO = 13'(BASE_ADDR);
    localparam logic [12:0] c_WIN_HI = 13'(int'(BASE_ADDR) + 4 * NUM_CH);

    logic [PS_W-1:0] r_presc;
    logic            r_tick;
    logic [31:0]     r_q;

    logic            w_in_win;
    logic [11:0]     w_off;
    logic [CH_W-1:0] w_ch;
    logic [1:0]      w_reg;
    logic [31:0]     w_rdata;
    logic [31:0]     w_unused_data;

    logic [1:0]       w_mode   [NUM_CH];
    logic             w_level  [NUM_CH];
    logic [DIV_W-1:0] w_period [NUM_CH];
    logic [DIV_W-1:0] w_pulse  [NUM_CH];
    logic [DIV_W-1:0] w_cnt    [NUM_CH];
    logic             w_busy   [NUM_CH];
    logic             w_pin    [NUM_CH];

    // Only the low data bits reach the channels
    assign w_unused_data = data;

    assign w_in_win = ({1'b0, address} >= c_WIN_LO) && ({1'b0, address} < c_WIN_HI);
    assign w_off    = address - BASE_ADDR;
    assign w_ch     = CH_W'(w_off >> 2);
    assign w_reg    = address[1:0];

    // Free-running prescaler; tick is registered one count early so it is
    // high exactly while the count sits at PRESCALE-1
    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= (r_presc == PS_W'(PRESCALE - 1)) ? '0 : r_presc + 1'b1;
            r_tick  <= (r_presc == PS_W'(PRESCALE - 2));
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_sel;
        assign w_sel = wren && w_in_win && (w_ch == CH_W'(gi));

        pin_timer_channel #(
            .DIV_W (DIV_W)
        ) u_channel (
            .clk          (clock),
            .rst          (reset),
            .i_tick       (r_tick),
            .i_wr_ctrl    (w_sel && (w_reg == REG_CTRL)),
            .i_wr_period  (w_sel && (w_reg == REG_PERIOD)),
            .i_wr_pulse   (w_sel && (w_reg == REG_PULSE)),
            .i_ctrl_wdata (data[3:0]),
            .i_val_wdata  (data[DIV_W-1:0]),
            .o_mode       (w_mode[gi]),
            .o_level      (w_level[gi]),
            .o_period     (w_period[gi]),
            .o_pulse      (w_pulse[gi]),
            .o_cnt        (w_cnt[gi]),
            .o_busy       (w_busy[gi]),
            .o_pin        (w_pin[gi])
        );

        assign pins[gi] = w_pin[gi];
    end

    // Read data for the addressed register; zero outside the window
    always_comb begin
        w_rdata = '0;
        if (w_in_win) begin
            case (w_reg)
                REG_CTRL:   w_rdata = {28'd0, 1'b0, w_level[w_ch], w_mode[w_ch]};
                REG_PERIOD: w_rdata = 32'(w_period[w_ch]);
                REG_PULSE:  w_rdata = 32'(w_pulse[w_ch]);
                default:    w_rdata = {16'(w_cnt[w_ch]), 14'd0, w_pin[w_ch], w_busy[w_ch]};
            endcase
        end
    end

    // Bus read data is registered every cycle, independent of wren
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_rdata;
        end
    end

    assign q    = r_q;
    assign tick = r_tick;

endmodule
`default_nettype wire
